// File: rtl/icw_ocw_sequencer_8259_if.sv
// Write-side bus from the 8259 data bus control block: the shared data byte
// plus the decoded command-word write strobes (all level signals).
interface icw_ocw_sequencer_8259_if;
    logic [7:0] internal_data_bus;
    logic       write_initial_command_word_1;
    logic       write_initial_command_word_2_4;
    logic       write_operation_control_word_1;
    logic       write_operation_control_word_2;
    logic       write_operation_control_word_3;

    // Bus control side: drives data and strobes.
    modport master (
        output internal_data_bus,
        output write_initial_command_word_1,
        output write_initial_command_word_2_4,
        output write_operation_control_word_1,
        output write_operation_control_word_2,
        output write_operation_control_word_3
    );

    // Sequencer side: consumes data and strobes.
    modport slave (
        input internal_data_bus,
        input write_initial_command_word_1,
        input write_initial_command_word_2_4,
        input write_operation_control_word_1,
        input write_operation_control_word_2,
        input write_operation_control_word_3
    );
endinterface

// File: rtl/icw_ocw_sequencer_8259.sv
// 8259A control-word sequencer: walks ICW1..ICW4, holds configuration and
// mask registers, and turns OCW2/OCW3 writes into pulses and mode bits.
module icw_ocw_sequencer_8259 #(
    parameter logic [7:0] RESET_MASK = 8'h00
) (
    input  logic                             clock,
    input  logic                             reset,
    icw_ocw_sequencer_8259_if.slave          bus,
    output logic [1:0]                       init_state,
    output logic                             init_done,
    output logic                             level_or_edge_triggered,
    output logic                             single_or_cascade,
    output logic [4:0]                       interrupt_vector_address,
    output logic [7:0]                       cascade_device_config,
    output logic                             special_fully_nested,
    output logic                             buffered_mode,
    output logic                             buffered_master,
    output logic                             auto_eoi,
    output logic                             u8086_mode,
    output logic [7:0]                       interrupt_mask,
    output logic                             rotate_on_auto_eoi,
    output logic                             ocw2_valid,
    output logic [2:0]                       ocw2_command,
    output logic [2:0]                       ocw2_level,
    output logic                             special_mask_mode,
    output logic                             read_isr_not_irr,
    output logic                             poll_command
);

    typedef enum logic [1:0] {
        READY     = 2'd0,
        WAIT_ICW2 = 2'd1,
        WAIT_ICW3 = 2'd2,
        WAIT_ICW4 = 2'd3
    } state_t;

    state_t     state_reg, state_next;
    logic       done_next;
    logic       ic4_reg;
    logic       icw1_prev_reg, icw24_prev_reg, ocw1_prev_reg, ocw2_prev_reg, ocw3_prev_reg;
    logic       icw1_event, icw24_event, ocw1_event, ocw2_event, ocw3_event;
    logic       icw24_go, ocw1_go, ocw2_go, ocw3_go, in_ready;
    logic [7:0] data;

    assign data       = bus.internal_data_bus;
    assign init_state = state_reg;
    assign in_ready   = (state_reg == READY);

    // Rising-edge detection: a strobe held for many cycles is one write.
    assign icw1_event  = bus.write_initial_command_word_1   & ~icw1_prev_reg;
    assign icw24_event = bus.write_initial_command_word_2_4 & ~icw24_prev_reg;
    assign ocw1_event  = bus.write_operation_control_word_1 & ~ocw1_prev_reg;
    assign ocw2_event  = bus.write_operation_control_word_2 & ~ocw2_prev_reg;
    assign ocw3_event  = bus.write_operation_control_word_3 & ~ocw3_prev_reg;

    // ICW1 wins outright; OCWs only take effect once initialization is complete.
    assign icw24_go = icw24_event & ~icw1_event;
    assign ocw1_go  = ocw1_event  & ~icw1_event & in_ready;
    assign ocw2_go  = ocw2_event  & ~icw1_event & in_ready;
    assign ocw3_go  = ocw3_event  & ~icw1_event & in_ready;

    // Strobe history for the edge detectors.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            icw1_prev_reg  <= 1'b0;
            icw24_prev_reg <= 1'b0;
            ocw1_prev_reg  <= 1'b0;
            ocw2_prev_reg  <= 1'b0;
            ocw3_prev_reg  <= 1'b0;
        end else begin
            icw1_prev_reg  <= bus.write_initial_command_word_1;
            icw24_prev_reg <= bus.write_initial_command_word_2_4;
            ocw1_prev_reg  <= bus.write_operation_control_word_1;
            ocw2_prev_reg  <= bus.write_operation_control_word_2;
            ocw3_prev_reg  <= bus.write_operation_control_word_3;
        end
    end

    // Initialization state register and completion flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= READY;
            init_done <= 1'b0;
        end else begin
            state_reg <= state_next;
            init_done <= done_next;
        end
    end

    // Next-state logic; SNGL and IC4 come from the ICW1 latched earlier.
    always_comb begin
        state_next = state_reg;
        done_next  = init_done;
        if (icw1_event) begin
            state_next = WAIT_ICW2;
            done_next  = 1'b0;
        end else if (icw24_go) begin
            case (state_reg)
                WAIT_ICW2: begin
                    if (!single_or_cascade) begin
                        state_next = WAIT_ICW3;
                    end else if (ic4_reg) begin
                        state_next = WAIT_ICW4;
                    end else begin
                        state_next = READY;
                        done_next  = 1'b1;
                    end
                end
                WAIT_ICW3: begin
                    if (ic4_reg) begin
                        state_next = WAIT_ICW4;
                    end else begin
                        state_next = READY;
                        done_next  = 1'b1;
                    end
                end
                WAIT_ICW4: begin
                    state_next = READY;
                    done_next  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Configuration, mask and OCW-derived registers and pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_or_edge_triggered  <= 1'b0;
            single_or_cascade        <= 1'b0;
            ic4_reg                  <= 1'b0;
            interrupt_vector_address <= 5'd0;
            cascade_device_config    <= 8'd0;
            special_fully_nested     <= 1'b0;
            buffered_mode            <= 1'b0;
            buffered_master          <= 1'b0;
            auto_eoi                 <= 1'b0;
            u8086_mode               <= 1'b0;
            interrupt_mask           <= RESET_MASK;
            rotate_on_auto_eoi       <= 1'b0;
            ocw2_valid               <= 1'b0;
            ocw2_command             <= 3'd0;
            ocw2_level               <= 3'd0;
            special_mask_mode        <= 1'b0;
            read_isr_not_irr         <= 1'b0;
            poll_command             <= 1'b0;
        end else begin
            ocw2_valid   <= 1'b0;
            poll_command <= 1'b0;
            if (icw1_event) begin
                level_or_edge_triggered <= data[3];
                single_or_cascade       <= data[1];
                ic4_reg                 <= data[0];
                cascade_device_config   <= 8'd0;
                {special_fully_nested, buffered_mode, buffered_master,
                 auto_eoi, u8086_mode}  <= 5'd0;
                interrupt_mask          <= RESET_MASK;
                rotate_on_auto_eoi      <= 1'b0;
                special_mask_mode       <= 1'b0;
                read_isr_not_irr        <= 1'b0;
            end else begin
                if (icw24_go) begin
                    case (state_reg)
                        WAIT_ICW2: interrupt_vector_address <= data[7:3];
                        WAIT_ICW3: cascade_device_config    <= data;
                        WAIT_ICW4: {special_fully_nested, buffered_mode, buffered_master,
                                    auto_eoi, u8086_mode} <= data[4:0];
                        default: ;
                    endcase
                end
                if (ocw1_go) begin
                    interrupt_mask <= data;
                end
                if (ocw2_go) begin
                    ocw2_valid   <= 1'b1;
                    ocw2_command <= data[7:5];
                    ocw2_level   <= data[2:0];
                    if (data[7:5] == 3'b100) begin
                        rotate_on_auto_eoi <= 1'b1;
                    end else if (data[7:5] == 3'b000) begin
                        rotate_on_auto_eoi <= 1'b0;
                    end
                end
                if (ocw3_go) begin
                    if (data[6]) begin
                        special_mask_mode <= data[5];
                    end
                    if (data[1]) begin
                        read_isr_not_irr <= data[0];
                    end
                    poll_command <= data[2];
                end
            end
        end
    end

endmodule

// File: tb/tb_icw_ocw_sequencer_8259.sv
// Directed table-driven bench for the 8259 control-word sequencer.
module tb_icw_ocw_sequencer_8259;

    localparam logic [7:0] RMASK = 8'hF0;

    localparam logic [3:0] K_ICW1 = 4'b0001;
    localparam logic [3:0] K_A0   = 4'b0010;
    localparam logic [3:0] K_OCW2 = 4'b0100;
    localparam logic [3:0] K_OCW3 = 4'b1000;

    typedef struct packed {
        logic [1:0] st;
        logic       done;
        logic       ltim;
        logic       sngl;
        logic [4:0] vec;
        logic [7:0] cas;
        logic [4:0] icw4;
        logic [7:0] mask;
        logic       rot;
        logic       smm;
        logic       risr;
    } outs_t;

    typedef struct {
        logic [3:0] kind;
        logic [7:0] data;
        int         hold;
        outs_t      exp;
        logic       pv;
        logic [5:0] pcl;
        logic       pp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] init_state;
    logic init_done, level_or_edge_triggered, single_or_cascade;
    logic [4:0] interrupt_vector_address;
    logic [7:0] cascade_device_config;
    logic special_fully_nested, buffered_mode, buffered_master, auto_eoi, u8086_mode;
    logic [7:0] interrupt_mask;
    logic rotate_on_auto_eoi, ocw2_valid;
    logic [2:0] ocw2_command, ocw2_level;
    logic special_mask_mode, read_isr_not_irr, poll_command;

    int total = 0;
    int bad   = 0;

    icw_ocw_sequencer_8259_if bus_if ();

    icw_ocw_sequencer_8259 #(.RESET_MASK(RMASK)) dut (
        .clock                    (clk),
        .reset                    (rst),
        .bus                      (bus_if.slave),
        .init_state               (init_state),
        .init_done                (init_done),
        .level_or_edge_triggered  (level_or_edge_triggered),
        .single_or_cascade        (single_or_cascade),
        .interrupt_vector_address (interrupt_vector_address),
        .cascade_device_config    (cascade_device_config),
        .special_fully_nested     (special_fully_nested),
        .buffered_mode            (buffered_mode),
        .buffered_master          (buffered_master),
        .auto_eoi                 (auto_eoi),
        .u8086_mode               (u8086_mode),
        .interrupt_mask           (interrupt_mask),
        .rotate_on_auto_eoi       (rotate_on_auto_eoi),
        .ocw2_valid               (ocw2_valid),
        .ocw2_command             (ocw2_command),
        .ocw2_level               (ocw2_level),
        .special_mask_mode        (special_mask_mode),
        .read_isr_not_irr         (read_isr_not_irr),
        .poll_command             (poll_command)
    );

    always #5 clk = ~clk;

    function automatic outs_t mk(input logic [1:0] st, input logic done, input logic ltim,
                                 input logic sngl, input logic [4:0] vec, input logic [7:0] cas,
                                 input logic [4:0] icw4, input logic [7:0] mask,
                                 input logic rot, input logic smm, input logic risr);
        outs_t o;
        o.st = st; o.done = done; o.ltim = ltim; o.sngl = sngl; o.vec = vec; o.cas = cas;
        o.icw4 = icw4; o.mask = mask; o.rot = rot; o.smm = smm; o.risr = risr;
        return o;
    endfunction

    function automatic outs_t sample();
        return mk(init_state, init_done, level_or_edge_triggered, single_or_cascade,
                  interrupt_vector_address, cascade_device_config,
                  {special_fully_nested, buffered_mode, buffered_master, auto_eoi, u8086_mode},
                  interrupt_mask, rotate_on_auto_eoi, special_mask_mode, read_isr_not_irr);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    task automatic drive(input logic [3:0] kind, input logic [7:0] data);
        bus_if.internal_data_bus              = data;
        bus_if.write_initial_command_word_1   = kind[0];
        bus_if.write_initial_command_word_2_4 = kind[1];
        bus_if.write_operation_control_word_1 = kind[1];
        bus_if.write_operation_control_word_2 = kind[2];
        bus_if.write_operation_control_word_3 = kind[3];
    endtask

    // Called at a falling edge: strobe for v.hold rising edges, then idle one cycle.
    task automatic apply(input string name, input vec_t v);
        int extra;
        extra = 0;
        drive(v.kind, v.data);
        @(negedge clk);
        check({name, " pulses"}, 64'({ocw2_valid, poll_command}), 64'({v.pv, v.pp}));
        if (v.pv) check({name, " cmd/lvl"}, 64'({ocw2_command, ocw2_level}), 64'(v.pcl));
        for (int h = 1; h < v.hold; h++) begin
            @(negedge clk);
            if (ocw2_valid || poll_command) extra++;
        end
        drive(4'b0000, 8'h00);
        @(negedge clk);
        if (ocw2_valid || poll_command) extra++;
        check({name, " pulse width"}, 64'(extra), 64'd0);
        check({name, " outs"}, 64'(sample()), 64'(v.exp));
    endtask

    vec_t tbl[25];
    vec_t tmp;

    initial begin
        tbl[0]  = '{K_ICW1, 8'h12, 1, mk(1,0,0,1,5'd0 ,8'h00,5'h00,RMASK,0,0,0), 0, 6'o00, 0};
        tbl[1]  = '{K_A0,   8'h48, 1, mk(0,1,0,1,5'd9 ,8'h00,5'h00,RMASK,0,0,0), 0, 6'o00, 0};
        tbl[2]  = '{K_A0,   8'hA5, 5, mk(0,1,0,1,5'd9 ,8'h00,5'h00,8'hA5,0,0,0), 0, 6'o00, 0};
        tbl[3]  = '{K_A0,   8'h3C, 1, mk(0,1,0,1,5'd9 ,8'h00,5'h00,8'h3C,0,0,0), 0, 6'o00, 0};
        tbl[4]  = '{K_OCW2, 8'h80, 3, mk(0,1,0,1,5'd9 ,8'h00,5'h00,8'h3C,1,0,0), 1, 6'b100000, 0};
        tbl[5]  = '{K_OCW3, 8'h6B, 1, mk(0,1,0,1,5'd9 ,8'h00,5'h00,8'h3C,1,1,1), 0, 6'o00, 0};
        tbl[6]  = '{K_OCW3, 8'h0C, 2, mk(0,1,0,1,5'd9 ,8'h00,5'h00,8'h3C,1,1,1), 0, 6'o00, 1};
        tbl[7]  = '{K_OCW2, 8'h65, 1, mk(0,1,0,1,5'd9 ,8'h00,5'h00,8'h3C,1,1,1), 1, 6'b011101, 0};
        tbl[8]  = '{K_OCW2, 8'h00, 1, mk(0,1,0,1,5'd9 ,8'h00,5'h00,8'h3C,0,1,1), 1, 6'b000000, 0};
        tbl[9]  = '{K_OCW3, 8'h4A, 1, mk(0,1,0,1,5'd9 ,8'h00,5'h00,8'h3C,0,0,0), 0, 6'o00, 0};
        tbl[10] = '{K_ICW1, 8'h19, 1, mk(1,0,1,0,5'd9 ,8'h00,5'h00,RMASK,0,0,0), 0, 6'o00, 0};
        tbl[11] = '{K_A0,   8'h20, 1, mk(2,0,1,0,5'd4 ,8'h00,5'h00,RMASK,0,0,0), 0, 6'o00, 0};
        tbl[12] = '{K_OCW2, 8'h80, 1, mk(2,0,1,0,5'd4 ,8'h00,5'h00,RMASK,0,0,0), 0, 6'o00, 0};
        tbl[13] = '{K_OCW3, 8'h6F, 1, mk(2,0,1,0,5'd4 ,8'h00,5'h00,RMASK,0,0,0), 0, 6'o00, 0};
        tbl[14] = '{K_A0,   8'h04, 1, mk(3,0,1,0,5'd4 ,8'h04,5'h00,RMASK,0,0,0), 0, 6'o00, 0};
        tbl[15] = '{K_A0,   8'h13, 1, mk(0,1,1,0,5'd4 ,8'h04,5'h13,RMASK,0,0,0), 0, 6'o00, 0};
        tbl[16] = '{K_ICW1, 8'h11, 1, mk(1,0,0,0,5'd4 ,8'h00,5'h00,RMASK,0,0,0), 0, 6'o00, 0};
        tbl[17] = '{K_A0,   8'h08, 1, mk(2,0,0,0,5'd1 ,8'h00,5'h00,RMASK,0,0,0), 0, 6'o00, 0};
        tbl[18] = '{K_ICW1, 8'h13, 1, mk(1,0,0,1,5'd1 ,8'h00,5'h00,RMASK,0,0,0), 0, 6'o00, 0};
        tbl[19] = '{K_A0,   8'hF8, 1, mk(3,0,0,1,5'd31,8'h00,5'h00,RMASK,0,0,0), 0, 6'o00, 0};
        tbl[20] = '{K_A0,   8'h0C, 1, mk(0,1,0,1,5'd31,8'h00,5'h0C,RMASK,0,0,0), 0, 6'o00, 0};
        tbl[21] = '{K_A0,   8'h5A, 1, mk(0,1,0,1,5'd31,8'h00,5'h0C,8'h5A,0,0,0), 0, 6'o00, 0};
        tbl[22] = '{4'b1111,8'h8E, 1, mk(1,0,1,1,5'd31,8'h00,5'h00,RMASK,0,0,0), 0, 6'o00, 0};
        tbl[23] = '{K_A0,   8'h48, 1, mk(0,1,1,1,5'd9 ,8'h00,5'h00,RMASK,0,0,0), 0, 6'o00, 0};
        tbl[24] = '{K_OCW2|K_OCW3, 8'h84, 1, mk(0,1,1,1,5'd9,8'h00,5'h00,RMASK,1,0,0), 1, 6'b100100, 1};

        rst = 1'b1;
        drive(4'b0000, 8'h00);
        repeat (2) @(negedge clk);
        check("reset outs", 64'(sample()), 64'(mk(0,0,0,0,0,8'h00,0,RMASK,0,0,0)));
        check("reset pulses", 64'({ocw2_valid, poll_command}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 25; i++) begin
            apply($sformatf("row%0d", i), tbl[i]);
        end

        // Asynchronous reset while waiting for ICW3.
        tmp = '{K_ICW1, 8'h19, 1, mk(1,0,1,0,5'd9,8'h00,5'h00,RMASK,1,0,0), 0, 6'o00, 0};
        tmp.exp.rot = 1'b0;
        apply("areset icw1", tmp);
        tmp = '{K_A0, 8'h28, 1, mk(2,0,1,0,5'd5,8'h00,5'h00,RMASK,0,0,0), 0, 6'o00, 0};
        apply("areset icw2", tmp);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("areset outs", 64'(sample()), 64'(mk(0,0,0,0,0,8'h00,0,RMASK,0,0,0)));
        check("areset pulses", 64'({ocw2_valid, poll_command}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tmp = '{K_ICW1, 8'h12, 1, mk(1,0,0,1,5'd0,8'h00,5'h00,RMASK,0,0,0), 0, 6'o00, 0};
        apply("post-reset icw1", tmp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icw_ocw_sequencer_8259.md
Name: icw_ocw_sequencer_8259

Overview:
Control-word sequencer for the 8259A PIC. It sits behind Data_Bus_Control_8259 and consumes that block's write strobes and internal_data_bus. It steps the ICW1→ICW2→[ICW3]→[ICW4] initialization sequence, holds all configuration and mask registers, and decodes OCW2/OCW3 into pulses and registers for the priority/ISR logic.

Parameters:
RESET_MASK, 8'h00, interrupt mask value loaded at reset and on every ICW1.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
internal_data_bus  in  8  data byte from bus control
write_initial_command_word_1  in  1  ICW1 strobe (level)
write_initial_command_word_2_4  in  1  A0=1 write strobe (level)
write_operation_control_word_1  in  1  A0=1 write strobe (level; asserted together with ICW2_4)
write_operation_control_word_2  in  1  OCW2 strobe (level)
write_operation_control_word_3  in  1  OCW3 strobe (level)
init_state  out  2  0=READY, 1=WAIT_ICW2, 2=WAIT_ICW3, 3=WAIT_ICW4
init_done  out  1  high in READY only after a completed sequence
level_or_edge_triggered  out  1  ICW1 bit3 (LTIM)
single_or_cascade  out  1  ICW1 bit1 (SNGL)
interrupt_vector_address  out  5  ICW2 bits 7:3
cascade_device_config  out  8  ICW3 byte
special_fully_nested  out  1  ICW4 bit4
buffered_mode  out  1  ICW4 bit3
buffered_master  out  1  ICW4 bit2
auto_eoi  out  1  ICW4 bit1
u8086_mode  out  1  ICW4 bit0
interrupt_mask  out  8  OCW1
rotate_on_auto_eoi  out  1  set by OCW2 R,SL,EOI=100, cleared by 000
ocw2_valid  out  1  one-cycle pulse on any OCW2
ocw2_command  out  3  OCW2 bits 7:5, valid with ocw2_valid
ocw2_level  out  3  OCW2 bits 2:0, valid with ocw2_valid
special_mask_mode  out  1  OCW3 SMM state
read_isr_not_irr  out  1  OCW3 read-register select
poll_command  out  1  one-cycle pulse, OCW3 bit2

Behaviour:
- Each strobe is registered. Event = strobe high AND previous sample low. A strobe held for N cycles counts once. Data is sampled on the event edge. Register outputs are updated by that same clock edge.
- Reset (async): init_state=READY, init_done=0, all config outputs 0, interrupt_mask=RESET_MASK, all pulses 0, special_mask_mode=0, read_isr_not_irr=0, edge-detect history=0.
- The ICW1 event is accepted in any state (re-init mid-sequence aborts the current sequence):
  - Next state WAIT_ICW2; init_done=0; latch LTIM, SNGL, IC4 (bit0).
  - Clear ICW4 fields to 0, cascade_device_config=0, interrupt_mask=RESET_MASK, special_mask_mode=0, read_isr_not_irr=0, rotate_on_auto_eoi=0.
- ICW2_4 event by state:
  - WAIT_ICW2: store vector. Next state is WAIT_ICW3 if SNGL=0; else WAIT_ICW4 if IC4=1; else READY with init_done=1.
  - WAIT_ICW3: store cascade byte. Next state is WAIT_ICW4 if IC4=1, else READY with init_done=1.
  - WAIT_ICW4: store bits 4:0. Next state READY, init_done=1.
  - READY: ignored.
- OCW1 event: writes interrupt_mask only when init_state=READY. Ignored in other states, even though it coincides with ICW2_4.
- OCW2/OCW3 events are ignored unless init_state=READY.
- OCW2 event:
  - ocw2_valid=1 for exactly one cycle, with command and level held stable during that cycle.
  - Command 100 sets rotate_on_auto_eoi; command 000 clears it.
- OCW3 event:
  - bits 6:5=11 sets SMM; 10 clears it; 0x leaves it unchanged.
  - bits 1:0=10 selects IRR; 11 selects ISR; 0x leaves the selection unchanged.
  - bit2=1 produces a one-cycle poll_command pulse.
- Simultaneous events in one cycle: ICW1 has highest priority and all other events that cycle are discarded. Otherwise the ICW2_4/OCW1 pair is resolved by state, and OCW2/OCW3 are processed independently.
- Reset asserted mid-sequence returns to the reset values immediately, without waiting for a clock edge.

Test Plan:
- Single mode, no ICW4: ICW1=8'h12, then A0 write 8'h48 → state 1→0, init_done=1, vector=5'b01001, SNGL=1, ICW4 fields 0.
- Cascade with ICW4: ICW1=8'h11, ICW2=8'h20, ICW3=8'h04, ICW4=8'h03 → states 1,2,3,0; cascade=8'h04, auto_eoi=1, u8086_mode=1, init_done=1.
- Strobe held 5 cycles with data 8'hA5 in READY → interrupt_mask=8'hA5 exactly once; a second write of 8'h3C after deassertion → mask=8'h3C.
- Re-init: ICW1=8'h11 then ICW2, then ICW1=8'h13 in WAIT_ICW3 → state=1, mask=RESET_MASK, init_done=0; an OCW2 issued during init produces no ocw2_valid.
- OCW2=8'h80 → rotate_on_auto_eoi=1 and one-cycle ocw2_valid with command 3'b100; OCW3=8'h6B → SMM=1, read_isr_not_irr=1; OCW3=8'h0C → single poll_command pulse, other fields unchanged.
- Async reset mid-ICW3 wait → all outputs take their reset values before the next clock edge.
